// File: rtl/pxs_pattern_gen.sv
// Test-pattern stage: appends an RGB field to the sync/coordinate/active pixel stream.
// Pattern mode and scroll offset are latched once per frame on the VSync leading edge.
module pxs_pattern_gen #(
    parameter int               GRID_LOG2   = 6,
    parameter int               CW          = 1,
    parameter logic [3*CW-1:0]  COLOR_A     = '1,
    parameter logic [3*CW-1:0]  COLOR_B     = '0,
    parameter logic             SYNC_ACTIVE = 1'b0
) (
    input  logic                 px_clk,
    input  logic                 reset,
    input  logic [1:0]           mode_i,
    input  logic [3:0]           speed_i,
    input  logic [22:0]          VGA_SCA_Str_i,
    output logic [22+3*CW:0]     VGA_SCA_RGB_Str_o
);

    // Blank stream word: coordinates zero, syncs inactive, not active video.
    localparam logic [22:0] IDLE_STR = {20'd0, ~SYNC_ACTIVE, ~SYNC_ACTIVE, 1'b0};

    logic [9:0]      x_in;
    logic [9:0]      y_in;
    logic            vs_in;
    logic            vs_prev;
    logic            frame_edge;
    logic [1:0]      mode_q;
    logic [9:0]      offset;
    logic [9:0]      xs;
    logic            tx0;
    logic            ty0;
    logic            p_next;
    logic [22:0]     s1_str;
    logic            s1_p;
    logic [22:0]     s2_str;
    logic [3*CW-1:0] s2_rgb;

    assign x_in       = VGA_SCA_Str_i[22:13];
    assign y_in       = VGA_SCA_Str_i[12:3];
    assign vs_in      = VGA_SCA_Str_i[1];
    assign frame_edge = (vs_in == SYNC_ACTIVE) && (vs_prev != SYNC_ACTIVE);

    assign xs  = x_in + ((mode_q == 2'd3) ? offset : 10'd0);
    assign tx0 = |((xs   >> GRID_LOG2) & 10'd1);
    assign ty0 = |((y_in >> GRID_LOG2) & 10'd1);

    always_comb begin
        p_next = tx0 ^ ty0;
        case (mode_q)
            2'd1:    p_next = tx0;
            2'd2:    p_next = ty0;
            default: p_next = tx0 ^ ty0;
        endcase
    end

    // Stage 1 sees the pre-update mode/offset; the frame edge lands in VSync blanking anyway.
    always_ff @(posedge px_clk) begin
        if (reset) begin
            vs_prev <= SYNC_ACTIVE;
            mode_q  <= 2'd0;
            offset  <= 10'd0;
            s1_str  <= IDLE_STR;
            s1_p    <= 1'b0;
            s2_str  <= IDLE_STR;
            s2_rgb  <= '0;
        end else begin
            vs_prev <= vs_in;
            if (frame_edge) begin
                mode_q <= mode_i;
                offset <= (mode_i == 2'd3) ? offset + {6'd0, speed_i} : 10'd0;
            end
            s1_str <= VGA_SCA_Str_i;
            s1_p   <= p_next;
            s2_str <= s1_str;
            s2_rgb <= s1_str[0] ? (s1_p ? COLOR_A : COLOR_B) : '0;
        end
    end

    assign VGA_SCA_RGB_Str_o = {s2_rgb, s2_str};

endmodule
